// File: rtl/ram_burst_ctrl.sv
// rtl/ram_burst_ctrl.sv - single-port RAM with direct/burst addressing and post-reset clear
module ram_burst_ctrl #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [AW-1:0]    ADDR,
    input  logic [WIDTH-1:0] DIN,
    input  logic             WE,
    input  logic             RE,
    input  logic             BURST,
    input  logic             LD,
    output logic [WIDTH-1:0] DOUT,
    output logic             VALID,
    output logic             BUSY
);
    localparam int DEPTH = 2**AW;
    localparam logic [AW-1:0] ONE  = AW'(1);
    localparam logic [AW-1:0] LAST = '1;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    clr_q, clr_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             busy;
    logic             access;
    logic [AW-1:0]    eff_addr;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;

    // A pointer load always targets ADDR for its own access
    assign eff_addr = (!BURST || LD) ? ADDR : ptr_q;

    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        ptr_d     = ptr_q;
        dout_d    = dout_q;
        valid_d   = 1'b0;
        busy      = 1'b0;
        access    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = eff_addr;
        mem_wdata = DIN;
        case (state_q)
            ST_CLEAR: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = clr_q;
                mem_wdata = '0;
                clr_d     = clr_q + ONE;
                if (clr_q == LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                access = WE | RE;
                mem_we = WE;
                if (RE) begin
                    dout_d  = mem_q[eff_addr];
                    valid_d = 1'b1;
                end
                if (LD) begin
                    ptr_d = access ? ADDR + ONE : ADDR;
                end else if (BURST && access) begin
                    ptr_d = ptr_q + ONE;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_CLEAR;
            clr_q   <= '0;
            ptr_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            ptr_q   <= ptr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    // Array kept out of the reset domain; the clear sequence defines its contents
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    assign DOUT  = dout_q;
    assign VALID = valid_q;
    assign BUSY  = busy;
endmodule

// File: doc/ram_burst_ctrl.md
RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data word width in bits.
REQ-002 The block SHALL have parameter AW, default 4, giving the address width; DEPTH SHALL equal 2**AW words.

Interface
REQ-003 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 ADDR  input  AW  direct access address, and pointer load value.
REQ-006 DIN  input  WIDTH  write data.
REQ-007 WE  input  1  write request for this cycle.
REQ-008 RE  input  1  read request for this cycle.
REQ-009 BURST  input  1  0 = use ADDR, 1 = use internal pointer PTR.
REQ-010 LD  input  1  load PTR from ADDR.
REQ-011 DOUT  output  WIDTH  registered read data.
REQ-012 VALID  output  1  one-cycle pulse marking new DOUT.
REQ-013 BUSY  output  1  high while the post-reset clear runs; all requests ignored.

Function
REQ-014 Storage SHALL be DEPTH words of WIDTH bits, synchronous write, synchronous registered read.
REQ-015 Effective address SHALL be ADDR when BURST=0 or LD=1, else PTR.
REQ-016 WE=1 with BUSY=0 SHALL write DIN to mem[effective address] at the rising edge.
REQ-017 RE=1 with BUSY=0 SHALL load DOUT with mem[effective address] and set VALID=1 on the same edge; latency is one cycle.
REQ-018 VALID SHALL be 0 in any cycle following an edge without an accepted read; DOUT SHALL hold its last value.
REQ-019 WE=1 and RE=1 together on the same address SHALL write DIN and return the old (pre-write) word on DOUT.
REQ-020 An access SHALL be one accepted WE, one accepted RE, or both in the same cycle.
REQ-021 When BURST=1, each access SHALL advance PTR by exactly one.
REQ-022 PTR SHALL wrap from DEPTH-1 to 0.
REQ-023 BURST=0 accesses SHALL leave PTR unchanged.
REQ-024 LD=1 with BUSY=0 SHALL load PTR with ADDR, or with ADDR+1 modulo DEPTH if an access occurs in the same cycle.
REQ-025 After RESET deasserts, a clear sequence SHALL write 0 to addresses 0..DEPTH-1, one per rising edge, in ascending order.
REQ-026 BUSY SHALL be 1 during the clear sequence and SHALL fall after the edge that clears address DEPTH-1; exactly DEPTH edges after RESET falls.
REQ-027 WE, RE and LD SHALL have no effect while BUSY=1.

Reset
REQ-028 RESET=1 SHALL immediately, without waiting for CLK, force DOUT=0, VALID=0, BUSY=1, PTR=0 and clear counter=0.
REQ-029 RESET asserted mid-clear or mid-burst SHALL abort the operation and restart the full clear on deassertion.
REQ-030 Memory contents are not defined while RESET=1; they are defined only after the clear completes.

Verification (WIDTH=8, AW=4)
REQ-031 Bench SHALL cover post-reset clear: RESET 1->0, then hold WE=1 -> BUSY=1 for exactly 16 edges; no writes during that time; afterwards reads of all 16 addresses return 0x00.
REQ-032 Bench SHALL cover direct access: write 0xA5 to ADDR=3, then RE with ADDR=3 -> next cycle DOUT=0xA5, VALID=1 for one cycle; VALID=0 after.
REQ-033 Bench SHALL cover burst wrap: LD with ADDR=14, BURST=1, write 0x11, 0x22, 0x33 on three edges -> mem[14]=0x11, mem[15]=0x22, mem[0]=0x33, PTR=1.
REQ-034 Bench SHALL cover read-during-write: mem[5]=0x0F, then WE=1, RE=1, ADDR=5, DIN=0xF0 -> DOUT=0x0F; a following read returns 0xF0.
REQ-035 Bench SHALL cover LD with access: LD=1, BURST=1, ADDR=7, RE=1 -> DOUT=mem[7], PTR=8.
REQ-036 Bench SHALL cover reset mid-burst: after 5 burst writes, pulse RESET asynchronously between edges -> DOUT=0, VALID=0, BUSY=1 before the next edge; the clear reruns for 16 edges.
